bdd_walk_engine: RTL and testbench

//  Programmable, sequential successor to the fixed per-output-bit BDD netlists: evaluates OUT_CH

---
 rtl/bdd_walk_pkg.sv | 42 ++++
 rtl/bdd_node_table.sv | 26 ++
 rtl/bdd_walk_engine.sv | 164 ++++++++++++++++
 tb/tb_bdd_walk_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_walk_pkg.sv
// Shared widths, node/child field layout, FSM state type and child-decoding helpers
// for the BDD walk engine and its node table.
package bdd_walk_pkg;

    localparam int IN_W       = 1894;
    localparam int NODE_DEPTH = 128;
    localparam int OUT_CH     = 4;
    localparam int MAX_STEPS  = 64;

    localparam int VAR_W   = $clog2(IN_W);
    localparam int PTR_W   = $clog2(NODE_DEPTH);
    localparam int CHILD_W = PTR_W + 1;
    localparam int NODE_W  = VAR_W + 2 * CHILD_W;
    localparam int CH_W    = $clog2(OUT_CH);
    localparam int STEP_W  = $clog2(MAX_STEPS);

    // Node word is {var, lo_child, hi_child}, hi_child in the LSBs.
    localparam int HI_LSB   = 0;
    localparam int LO_LSB   = CHILD_W;
    localparam int VAR_LSB  = 2 * CHILD_W;
    localparam int TERM_BIT = CHILD_W - 1;

    typedef logic [CHILD_W-1:0] child_t;
    typedef logic [NODE_W-1:0]  node_t;

    localparam child_t TERM_ZERO = {1'b1, {PTR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_e;

    function automatic logic is_term(input child_t c);
        return c[TERM_BIT];
    endfunction

    function automatic logic [PTR_W-1:0] child_ptr(input child_t c);
        return c[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/bdd_node_table.sv
// Node table shared by all channels: one synchronous write port, one
// combinational read port so the walker can follow a node every cycle.
module bdd_node_table
    import bdd_walk_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  node_t            wdata,
    input  logic [PTR_W-1:0] raddr,
    output node_t            rdata
);

    node_t mem_q [NODE_DEPTH];

    // NOTE: the array has no reset; software must load every node it references
    // before use, and leaving it out of reset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bdd_walk_engine.sv
// Sequential BDD evaluator: walks one node per cycle through a writable node table,
// producing OUT_CH predictor bits per captured input vector, valid/ready on both sides.
module bdd_walk_engine
    import bdd_walk_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [PTR_W-1:0]    cfg_addr,
    input  logic [NODE_W-1:0]   cfg_wdata,
    input  logic                root_we,
    input  logic [CH_W-1:0]     root_ch,
    input  logic [CHILD_W-1:0]  root_wdata,
    output logic                cfg_ready,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_CH-1:0]   out_bits,
    output logic                out_err
);

    localparam logic [VAR_W-1:0]  VAR_LIMIT = VAR_W'(IN_W);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(OUT_CH - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

    state_e              state_q, state_d;
    logic [IN_W-1:0]     vec_q, vec_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    child_t              cur_q, cur_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [OUT_CH-1:0]   bits_q, bits_d;
    logic                err_q, err_d;
    child_t              root_q [OUT_CH];
    child_t              root_d [OUT_CH];

    node_t               node_rd;
    logic [VAR_W-1:0]    node_var;
    child_t              node_lo, node_hi, next_child;
    logic [CH_W-1:0]     ch_nxt;
    logic                var_bit, cur_term, last_ch, loop_err, ch_done, accept;

    bdd_node_table u_node_table (
        .clk   (clk),
        .we    (cfg_we && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (child_ptr(cur_q)),
        .rdata (node_rd)
    );

    // Decode the node under cur_q and decide what this WALK cycle does.
    always_comb begin
        node_var   = node_rd[VAR_LSB +: VAR_W];
        node_lo    = node_rd[LO_LSB +: CHILD_W];
        node_hi    = node_rd[HI_LSB +: CHILD_W];
        var_bit    = (node_var < VAR_LIMIT) ? vec_q[node_var] : 1'b0;
        next_child = var_bit ? node_hi : node_lo;
        cur_term   = is_term(cur_q);
        last_ch    = (ch_q == LAST_CH);
        ch_nxt     = ch_q + CH_W'(1);
        loop_err   = !cur_term && !is_term(next_child) && (steps_q == LAST_STEP);
        ch_done    = cur_term || loop_err;
    end

    assign accept = in_valid && in_ready;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = WALK;
            WALK:    if (ch_done && last_ch) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        cfg_ready = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        out_bits  = bits_q;
        out_err   = err_q;
    end

    // NOTE: every variable gets its hold value first, so no path through this
    // block leaves one unassigned and no latch is inferred.
    always_comb begin
        vec_d   = vec_q;
        ch_d    = ch_q;
        cur_d   = cur_q;
        steps_d = steps_q;
        bits_d  = bits_q;
        err_d   = err_q;
        root_d  = root_q;

        if (root_we && cfg_ready) begin
            root_d[root_ch] = root_wdata;
        end

        if (state_q == IDLE && accept) begin
            vec_d   = in_vec;
            ch_d    = '0;
            cur_d   = root_q[0];
            steps_d = '0;
            bits_d  = '0;
            err_d   = 1'b0;
        end else if (state_q == WALK) begin
            if (cur_term) begin
                bits_d[ch_q] = cur_q[0];
            end else begin
                cur_d   = next_child;
                steps_d = steps_q + STEP_W'(1);
                if (loop_err) begin
                    bits_d[ch_q] = 1'b0;
                    err_d        = 1'b1;
                end
            end
            // A finished channel (terminal or loop abort) hands over to the next root.
            if (ch_done && !last_ch) begin
                ch_d    = ch_nxt;
                cur_d   = root_q[ch_nxt];
                steps_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q    <= '0;
            cur_q   <= TERM_ZERO;
            steps_q <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < OUT_CH; i++) begin
                root_q[i] <= TERM_ZERO;
            end
        end else begin
            ch_q    <= ch_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
            root_q  <= root_d;
        end
    end

    // Captured vector only matters once accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

endmodule

// File: tb/tb_bdd_walk_engine.sv
// Directed bench for bdd_walk_engine: hand-built BDDs, results, latencies,
// loop-abort boundary, back-pressure, dropped config writes and mid-walk reset.
module tb_bdd_walk_engine;

  localparam int IN_W = 1894;
  localparam logic [7:0] T0 = 8'h80;
  localparam logic [7:0] T1 = 8'h81;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [6:0]        cfg_addr;
  logic [26:0]       cfg_wdata;
  logic              root_we;
  logic [1:0]        root_ch;
  logic [7:0]        root_wdata;
  logic              cfg_ready;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_bits;
  logic              out_err;

  int n_checks = 0;
  int n_errors = 0;

  bdd_walk_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .root_we    (root_we),
    .root_ch    (root_ch),
    .root_wdata (root_wdata),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] nd(input int n);
    return {1'b0, n[6:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_node(input int addr, input int var_idx, input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr[6:0];
    cfg_wdata = {var_idx[10:0], lo, hi};
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic wr_root(input int ch, input logic [7:0] val);
    @(negedge clk);
    root_we    = 1'b1;
    root_ch    = ch[1:0];
    root_wdata = val;
    @(negedge clk);
    root_we    = 1'b0;
  endtask

  task automatic start_req(input logic [IN_W-1:0] vec);
    @(negedge clk);
    in_vec   = vec;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle plus every following cycle until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
  endtask

  task automatic take_resp();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [IN_W-1:0] vec,
                     input logic [3:0] exp_bits, input logic exp_err, input int exp_lat);
    int lat;
    start_req(vec);
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_bits"}, out_bits, exp_bits);
    check({tag, "_err"}, out_err, exp_err);
    take_resp();
  endtask

  initial begin
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] v_ones;
    int lat;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    root_we = 1'b0; root_ch = '0; root_wdata = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    v_ones = '1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bits", out_bits, 4'b0000);
    check("rst_out_err", out_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_cfg_ready", cfg_ready, 1'b1);

    // Reset roots are terminal 0
    for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom);
    run("reset_roots", v, 4'b0000, 1'b0, 5);

    // T1: all roots terminal {0,1,1,0}
    wr_root(0, T0);
    wr_root(1, T1);
    wr_root(2, T1);
    wr_root(3, T0);
    run("t1", v, 4'b0110, 1'b0, 5);

    // T2: node write and root write in the same cycle both apply
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = {11'd78, T0, nd(1)};
    root_we = 1'b1; root_ch = 2'd0; root_wdata = nd(0);
    @(negedge clk);
    cfg_we = 1'b0; root_we = 1'b0;
    wr_node(1, 1722, T1, T0);
    v = '0; v[78] = 1'b1;
    run("t2_hi_lo", v, 4'b0111, 1'b0, 7);
    v = '0;
    run("t2_lo", v, 4'b0110, 1'b0, 6);
    v = '0; v[78] = 1'b1; v[1722] = 1'b1;
    run("t2_hi_hi", v, 4'b0110, 1'b0, 7);

    // Variable index beyond the vector reads as 0
    wr_node(2, 2000, T1, T0);
    wr_root(3, nd(2));
    run("var_oob", v_ones, 4'b1110, 1'b0, 8);

    // Step-limit boundary: chain nodes 10..74, node 74 ends in T1
    for (int n = 10; n < 74; n++) wr_node(n, 0, nd(n + 1), nd(n + 1));
    wr_node(74, 0, T1, T1);
    wr_root(0, T0);
    wr_root(1, nd(11));
    wr_root(2, T1);
    wr_root(3, T0);
    run("steps_64_ok", v_ones, 4'b0110, 1'b0, 69);
    wr_root(1, nd(10));
    run("steps_65_abort", v_ones, 4'b0100, 1'b1, 68);

    // T3: self-loop on channel 2, then acyclic roots clear the error
    wr_node(5, 3, nd(5), nd(5));
    wr_root(1, T1);
    wr_root(2, nd(5));
    run("t3_loop", v_ones, 4'b0010, 1'b1, 68);
    wr_root(2, T1);
    run("t3_clear", v_ones, 4'b0110, 1'b0, 5);

    // T4: back-pressure in DONE, writes dropped, one bubble before re-accept
    wr_root(0, nd(0));
    wr_root(1, T0);
    wr_root(2, T0);
    v = '0; v[78] = 1'b1;
    start_req(v);
    wait_valid(lat);
    check("t4_lat", lat, 7);
    check("t4_bits", out_bits, 4'b0001);
    cfg_we = 1'b1; cfg_addr = 7'd1; cfg_wdata = {11'd1722, T0, T1};
    root_we = 1'b1; root_ch = 2'd1; root_wdata = T1;
    in_valid = 1'b1; in_vec = v;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_bits", out_bits, 4'b0001);
      check("t4_hold_in_ready", in_ready, 1'b0);
      check("t4_hold_cfg_ready", cfg_ready, 1'b0);
      @(negedge clk);
    end
    cfg_we = 1'b0; root_we = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t4_bubble_out_valid", out_valid, 1'b0);
    check("t4_bubble_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("t4_readback_lat", lat, 7);
    check("t4_readback_bits", out_bits, 4'b0001);
    take_resp();

    // T5: reset for one cycle in the middle of a long walk
    wr_root(1, nd(11));
    start_req(v_ones);
    repeat (5) @(negedge clk);
    check("t5_walking", out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_out_bits", out_bits, 4'b0000);
    check("t5_out_err", out_err, 1'b0);
    run("t5_after", v_ones, 4'b0000, 1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
